ps2_host_tx: RTL and testbench
==============================

// Module: ps2_host_tx
// PURPOSE
//  Host-to-device PS/2 transmitter. It sends one command byte to the keyboard, for
//  example 0xED (set LEDs) or 0xFF (reset). It sits beside KEYBOARD_CONTROLLER on the
//  same open-drain PS2CLK/DATA pair. It inhibits the bus, issues a start bit, shifts
//  out data, parity and stop on device clocks, then checks the device ACK.
// PARAMETERS
//  INHIBIT_CYCLES  5000    clocks PS2CLK is held low before the start bit (100us @50MHz)
//  START_TIMEOUT   750000  max clocks from clock release to first device falling edge (15ms)
//  FRAME_TIMEOUT   100000  max clocks from first falling edge to ACK sampled (2ms)
// PORTS
//  CLK_50MHZ   in   1  system clock
//  RST_N       in   1  synchronous reset, active low
//  TX_DATA     in   8  command byte; captured on accept
//  TX_VALID    in   1  request to send TX_DATA
//  TX_READY    out  1  high in IDLE only; accept = TX_VALID & TX_READY
//  BUSY        out  1  high in every state except IDLE
//  DONE        out  1  one-cycle pulse: frame sent, ACK received
//  ACK_ERR     out  1  one-cycle pulse: DATA sampled high on the ACK edge
//  TIMEOUT_ERR out  1  one-cycle pulse: START_TIMEOUT or FRAME_TIMEOUT expired
//  PS2CLK_IN   in   1  PS2CLK line level (asynchronous)
//  PS2DATA_IN  in   1  DATA line level (asynchronous)
//  PS2CLK_OE   out  1  1 = drive PS2CLK low; 0 = release (pull-up)
//  PS2DATA_OE  out  1  1 = drive DATA low; 0 = release
// BEHAVIOUR
//  - Reset (RST_N=0 at a rising edge):
//    - state=IDLE; TX_READY=1; BUSY=0; DONE, ACK_ERR, TIMEOUT_ERR = 0.
//    - Both OE outputs = 0, so the lines are released. This also applies mid-frame.
//  - PS2CLK_IN and PS2DATA_IN pass through 2-flop synchronisers.
//  - fall = sync_clk_d & ~sync_clk. Edge detection lags the pin by 3 clocks.
//  - Odd parity: par = ~^data_reg. Data is shifted out LSB first.
//  - IDLE:
//    - OE=00.
//    - On accept: data_reg<=TX_DATA, cnt<=0, go to INHIBIT.
//    - TX_VALID while BUSY is ignored; no queueing.
//  - INHIBIT:
//    - PS2CLK_OE=1, PS2DATA_OE=0 for INHIBIT_CYCLES clocks.
//    - On the last cycle PS2DATA_OE<=1 (start bit).
//    - Then go to REQ with PS2CLK_OE<=0 and PS2DATA_OE held at 1.
//  - REQ:
//    - Wait for fall. Timer over START_TIMEOUT -> TIMEOUT_ERR pulse, release both, go to IDLE.
//    - First fall -> PS2DATA_OE<=~data_reg[0], bitn<=1, go to SHIFT, frame timer<=0.
//  - SHIFT: each fall, with k = bitn:
//    - k=1..7: PS2DATA_OE<=~data_reg[k].
//    - k=8: PS2DATA_OE<=~par.
//    - k=9: PS2DATA_OE<=0 (stop = released high).
//    - k=10: sample sync DATA; go to ACKWAIT.
//    - bitn increments on each fall; 11 falls total including the REQ fall.
//  - ACK sampled 0 -> go to ACKWAIT, wait until sync clk=1 and sync data=1.
//    - Then DONE pulse, go to IDLE.
//  - ACK sampled 1 -> ACK_ERR pulse, go to IDLE immediately.
//  - FRAME_TIMEOUT: measured from the REQ fall through ACKWAIT.
//    - Expiry -> TIMEOUT_ERR, release both OE, go to IDLE.
//    - Expiry in the same cycle as a fall: the timeout wins.
//  - Exactly one of DONE/ACK_ERR/TIMEOUT_ERR pulses per accepted byte.
//    - TX_READY returns high the cycle after that pulse.
//  - PS2CLK_OE is never 1 outside INHIBIT. PS2DATA_OE is never 1 in IDLE.
// TESTING  (INHIBIT_CYCLES=8, START_TIMEOUT=200, FRAME_TIMEOUT=2000; device model clocks 40-clk period)
//  1) Send 0xED; model ACKs.
//     - PS2CLK_OE high for 8 clks; then DATA driven low.
//     - Model samples bits 1,0,1,1,0,1,1,1 (LSB first), then parity 1, stop 1.
//     - Exactly one DONE pulse.
//  2) Send 0x00.
//     - Sampled parity=1, stop=1.
//     - Send 0xFF: parity=1.
//     - Send 0x01: parity=0.
//     - Each ends with DONE.
//  3) Model never clocks after the request.
//     - TIMEOUT_ERR 200 clks after PS2CLK_OE falls.
//     - Both OE=0; TX_READY=1.
//  4) Model leaves DATA high on the 11th falling edge.
//     - ACK_ERR pulse; no DONE; TX_READY=1 next cycle.
//  5) RST_N=0 for one clock after the 5th falling edge.
//     - Next cycle: OE=00, TX_READY=1, no status pulse.
//     - A following 0xF4 send completes with DONE.
//  6) TX_VALID held high with 0xAA during a 0x55 frame.
//     - 0xAA is not captured until TX_READY=1.
//     - The second frame carries 0xAA only after the first frame's DONE.

Source files
------------

// File: rtl/ps2_host_tx_if.sv
// Command handshake plus open-drain PS/2 line controls for ps2_host_tx.
// master = command source / line model, slave = transmitter.
interface ps2_host_tx_if;
    logic [7:0] TX_DATA;
    logic       TX_VALID;
    logic       TX_READY;
    logic       BUSY;
    logic       DONE;
    logic       ACK_ERR;
    logic       TIMEOUT_ERR;
    logic       PS2CLK_IN;
    logic       PS2DATA_IN;
    logic       PS2CLK_OE;
    logic       PS2DATA_OE;

    modport master (
        output TX_DATA, TX_VALID, PS2CLK_IN, PS2DATA_IN,
        input  TX_READY, BUSY, DONE, ACK_ERR, TIMEOUT_ERR, PS2CLK_OE, PS2DATA_OE
    );

    modport slave (
        input  TX_DATA, TX_VALID, PS2CLK_IN, PS2DATA_IN,
        output TX_READY, BUSY, DONE, ACK_ERR, TIMEOUT_ERR, PS2CLK_OE, PS2DATA_OE
    );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, start bit, 8 data + odd parity
// + stop shifted on device clock falls, then ACK check with start/frame timeouts.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int START_TIMEOUT  = 750000,
    parameter int FRAME_TIMEOUT  = 100000
) (
    input  logic CLK_50MHZ,
    input  logic RST_N,
    ps2_host_tx_if.slave bus
);
    localparam int CNT_MAX0 = (START_TIMEOUT > FRAME_TIMEOUT) ? START_TIMEOUT : FRAME_TIMEOUT;
    localparam int CNT_MAX  = (CNT_MAX0 > INHIBIT_CYCLES) ? CNT_MAX0 : INHIBIT_CYCLES;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_INHIBIT, S_REQ, S_SHIFT, S_ACKWAIT
    } state_t;

    state_t           r_state, w_state_nxt;
    logic             r_clk_s1, r_clk_s2, r_clk_d;
    logic             r_dat_s1, r_dat_s2;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_bitn;
    logic [7:0]       r_data;
    logic             r_clk_oe, r_dat_oe;

    logic w_fall, w_accept, w_par, w_inh_last, w_start_tmo, w_frame_tmo;
    logic w_ack_edge, w_line_idle;
    logic w_ready, w_busy, w_done, w_ack_err, w_tmo;

    assign w_fall      = r_clk_d & ~r_clk_s2;
    assign w_accept    = bus.TX_VALID & w_ready;
    assign w_par       = ~^r_data;
    assign w_inh_last  = (r_cnt == CNT_W'(INHIBIT_CYCLES - 1));
    assign w_start_tmo = (r_cnt == CNT_W'(START_TIMEOUT));
    assign w_frame_tmo = (r_cnt == CNT_W'(FRAME_TIMEOUT));
    assign w_ack_edge  = w_fall & (r_bitn == 4'd10);
    assign w_line_idle = r_clk_s2 & r_dat_s2;

    // Synchronisers come out of reset at the idle (high) line level so reset
    // itself never looks like a clock fall.
    always_ff @(posedge CLK_50MHZ) begin
        if (!RST_N) begin
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
            r_clk_d  <= 1'b1;
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
        end else begin
            r_clk_s1 <= bus.PS2CLK_IN;
            r_clk_s2 <= r_clk_s1;
            r_clk_d  <= r_clk_s2;
            r_dat_s1 <= bus.PS2DATA_IN;
            r_dat_s2 <= r_dat_s1;
        end
    end

    always_ff @(posedge CLK_50MHZ) begin
        if (!RST_N) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (w_accept) w_state_nxt = S_INHIBIT;
            S_INHIBIT: if (w_inh_last) w_state_nxt = S_REQ;
            S_REQ: begin
                if (w_start_tmo) w_state_nxt = S_IDLE;
                else if (w_fall) w_state_nxt = S_SHIFT;
            end
            S_SHIFT: begin
                if (w_frame_tmo)     w_state_nxt = S_IDLE;
                else if (w_ack_edge) w_state_nxt = r_dat_s2 ? S_IDLE : S_ACKWAIT;
            end
            S_ACKWAIT: if (w_frame_tmo || w_line_idle) w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    // Status pulses fire in the last busy cycle, so TX_READY rises the cycle after.
    always_comb begin
        w_ready   = (r_state == S_IDLE);
        w_busy    = (r_state != S_IDLE);
        w_done    = (r_state == S_ACKWAIT) & ~w_frame_tmo & w_line_idle;
        w_ack_err = (r_state == S_SHIFT) & ~w_frame_tmo & w_ack_edge & r_dat_s2;
        w_tmo     = ((r_state == S_REQ) & w_start_tmo) |
                    (((r_state == S_SHIFT) | (r_state == S_ACKWAIT)) & w_frame_tmo);
    end

    // One counter serves as inhibit timer, start timer and frame timer.
    always_ff @(posedge CLK_50MHZ) begin
        if (!RST_N) begin
            r_clk_oe <= 1'b0;
            r_dat_oe <= 1'b0;
            r_cnt    <= '0;
            r_bitn   <= '0;
            r_data   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_clk_oe <= 1'b0;
                    r_dat_oe <= 1'b0;
                    if (w_accept) begin
                        r_data   <= bus.TX_DATA;
                        r_cnt    <= '0;
                        r_clk_oe <= 1'b1;
                    end
                end
                S_INHIBIT: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_inh_last) begin
                        r_clk_oe <= 1'b0;
                        r_dat_oe <= 1'b1;
                        r_cnt    <= '0;
                    end
                end
                S_REQ: begin
                    if (w_start_tmo) begin
                        r_dat_oe <= 1'b0;
                    end else if (w_fall) begin
                        r_dat_oe <= ~r_data[0];
                        r_bitn   <= 4'd1;
                        r_cnt    <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_SHIFT: begin
                    if (w_frame_tmo) begin
                        r_dat_oe <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (w_fall) begin
                            r_bitn <= r_bitn + 4'd1;
                            case (r_bitn)
                                4'd1, 4'd2, 4'd3, 4'd4,
                                4'd5, 4'd6, 4'd7: r_dat_oe <= ~r_data[r_bitn[2:0]];
                                4'd8:             r_dat_oe <= ~w_par;
                                default:          r_dat_oe <= 1'b0;
                            endcase
                        end
                    end
                end
                S_ACKWAIT: begin
                    r_dat_oe <= 1'b0;
                    r_cnt    <= r_cnt + CNT_W'(1);
                end
                default: begin
                    r_clk_oe <= 1'b0;
                    r_dat_oe <= 1'b0;
                end
            endcase
        end
    end

    assign bus.TX_READY    = w_ready;
    assign bus.BUSY        = w_busy;
    assign bus.DONE        = w_done;
    assign bus.ACK_ERR     = w_ack_err;
    assign bus.TIMEOUT_ERR = w_tmo;
    assign bus.PS2CLK_OE   = r_clk_oe;
    assign bus.PS2DATA_OE  = r_dat_oe;
endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a wired-AND PS/2 device model (40-clk bit period).
module tb_ps2_host_tx;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic dev_clk = 1'b1;
    logic dev_data = 1'b1;
    logic mon_en = 1'b0;

    int n_cmp = 0, n_err = 0;
    int n_done = 0, n_ack = 0, n_tmo = 0, n_acc = 0;
    logic pend = 1'b0, busy_q = 1'b0;

    always #5 clk = ~clk;

    ps2_host_tx_if bus();

    assign bus.PS2CLK_IN  = ~bus.PS2CLK_OE & dev_clk;
    assign bus.PS2DATA_IN = ~bus.PS2DATA_OE & dev_data;

    ps2_host_tx #(.INHIBIT_CYCLES(8), .START_TIMEOUT(200), .FRAME_TIMEOUT(2000)) dut (
        .CLK_50MHZ (clk),
        .RST_N     (rst_n),
        .bus       (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Status pulses, accept count (BUSY rising) and idle-line invariant.
    always @(negedge clk) begin
        if (mon_en) begin
            if (pend) chk("rdy_after_pulse", bus.TX_READY, 1);
            pend = bus.DONE | bus.ACK_ERR | bus.TIMEOUT_ERR;
            if (pend) chk("one_pulse", $countones({bus.DONE, bus.ACK_ERR, bus.TIMEOUT_ERR}), 1);
            if (bus.TX_READY) chk("idle_oe", {bus.PS2CLK_OE, bus.PS2DATA_OE}, 0);
            n_done += int'(bus.DONE);
            n_ack  += int'(bus.ACK_ERR);
            n_tmo  += int'(bus.TIMEOUT_ERR);
            if (bus.BUSY && !busy_q) n_acc++;
            busy_q = bus.BUSY;
        end
    end

    task automatic send(input logic [7:0] b);
        chk("rdy_before_send", bus.TX_READY, 1);
        bus.TX_DATA  = b;
        bus.TX_VALID = 1'b1;
        tick();
        bus.TX_VALID = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!bus.TX_READY && n < 200) begin tick(); n++; end
        chk("idle_reached", bus.TX_READY, 1);
    endtask

    // Device: waits for the request, then clocks nfall falls, sampling the line
    // on each rise; smp = {stop, parity, data[7:0]}. Aborts low on fall nfall < 11.
    task automatic run_dev(input bit ack, input int nfall, output logic [9:0] smp);
        int n = 0;
        smp = '0;
        while (!(bus.PS2CLK_OE == 1'b0 && bus.PS2DATA_OE == 1'b1) && n < 100) begin tick(); n++; end
        chk("req_seen", (n < 100), 1);
        repeat (10) tick();
        for (int i = 1; i <= 11; i++) begin
            dev_clk = 1'b0;
            if (i == nfall && nfall < 11) begin
                repeat (5) tick();
                return;
            end
            repeat (20) tick();
            dev_clk = 1'b1;
            if (i <= 10) smp[i-1] = bus.PS2DATA_IN;
            repeat (10) tick();
            if (i == 10 && ack) dev_data = 1'b0;
            repeat (10) tick();
        end
        dev_data = 1'b1;
    endtask

    logic [7:0] vb [4] = '{8'hED, 8'h00, 8'hFF, 8'h01};
    logic       vp [4] = '{1'b1, 1'b1, 1'b1, 1'b0};

    initial begin
        logic [9:0] smp;
        int n, d0, a0, e0, t0, s0;
        bus.TX_DATA  = 8'h00;
        bus.TX_VALID = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        chk("rst_ready", bus.TX_READY, 1);
        chk("rst_busy", bus.BUSY, 0);
        chk("rst_oe", {bus.PS2CLK_OE, bus.PS2DATA_OE}, 0);
        chk("rst_pulses", {bus.DONE, bus.ACK_ERR, bus.TIMEOUT_ERR}, 0);
        mon_en = 1'b1;
        tick();

        // Byte table: inhibit length, data bits, parity, stop, single DONE
        for (int v = 0; v < 4; v++) begin
            d0 = n_done; e0 = n_ack; t0 = n_tmo;
            send(vb[v]);
            if (v == 0) begin
                chk("inh_dat_oe0", bus.PS2DATA_OE, 0);
                n = 0;
                while (bus.PS2CLK_OE && n < 50) begin n++; tick(); end
                chk("inh_len", n, 8);
                chk("start_bit", bus.PS2DATA_OE, 1);
            end
            run_dev(1'b1, 11, smp);
            wait_idle();
            chk("data", smp[7:0], vb[v]);
            chk("parity", smp[8], vp[v]);
            chk("stop", smp[9], 1);
            chk("done_cnt", n_done - d0, 1);
            chk("no_err", (n_ack - e0) + (n_tmo - t0), 0);
            repeat (5) tick();
        end

        // Device never clocks: start timeout
        t0 = n_tmo; d0 = n_done;
        send(8'h12);
        n = 0;
        while (bus.PS2CLK_OE == 1'b0 && n < 20) begin tick(); n++; end
        n = 0;
        while (bus.PS2CLK_OE == 1'b1 && n < 20) begin tick(); n++; end
        n = 0;
        while (!bus.TIMEOUT_ERR && n < 400) begin tick(); n++; end
        chk("start_tmo_lat", n, 200);
        tick();
        chk("tmo_oe", {bus.PS2CLK_OE, bus.PS2DATA_OE}, 0);
        chk("tmo_ready", bus.TX_READY, 1);
        chk("tmo_cnt", n_tmo - t0, 1);
        chk("tmo_no_done", n_done - d0, 0);
        repeat (5) tick();

        // No ACK from the device
        e0 = n_ack; d0 = n_done;
        send(8'hED);
        run_dev(1'b0, 11, smp);
        wait_idle();
        chk("ackerr_cnt", n_ack - e0, 1);
        chk("ackerr_no_done", n_done - d0, 0);
        repeat (5) tick();

        // Reset after the 5th fall, then a clean 0xF4
        s0 = n_done + n_ack + n_tmo;
        send(8'hF4);
        run_dev(1'b1, 5, smp);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mid_rst_oe", {bus.PS2CLK_OE, bus.PS2DATA_OE}, 0);
        chk("mid_rst_ready", bus.TX_READY, 1);
        chk("mid_rst_pulse", (n_done + n_ack + n_tmo) - s0, 0);
        dev_clk = 1'b1;
        repeat (5) tick();
        d0 = n_done;
        send(8'hF4);
        run_dev(1'b1, 11, smp);
        wait_idle();
        chk("f4_data", smp[7:0], 8'hF4);
        chk("f4_parity", smp[8], 0);
        chk("f4_done", n_done - d0, 1);
        repeat (5) tick();

        // TX_VALID held with 0xAA during a 0x55 frame
        d0 = n_done; a0 = n_acc;
        bus.TX_DATA  = 8'h55;
        bus.TX_VALID = 1'b1;
        tick();
        bus.TX_DATA = 8'hAA;
        run_dev(1'b1, 11, smp);
        chk("f55_data", smp[7:0], 8'h55);
        n = 0;
        while (n_done == d0 && n < 200) begin tick(); n++; end
        chk("f55_done", n_done - d0, 1);
        chk("f55_acc_once", n_acc - a0, 1);
        tick();
        tick();
        bus.TX_VALID = 1'b0;
        chk("faa_acc", n_acc - a0, 2);
        run_dev(1'b1, 11, smp);
        wait_idle();
        chk("faa_data", smp[7:0], 8'hAA);
        chk("faa_parity", smp[8], 1);
        chk("faa_done", n_done - d0, 2);
        repeat (5) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
